// File: rtl/cmos_nor_srff_bank.sv
// Bank of WIDTH independent set/reset flip-flops with NOR-latch semantics.
// It provides complementary outputs, selectable S=R=1 resolution, and registered conflict status.
module cmos_nor_srff_bank #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             nor_all,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("cmos_nor_srff_bank: WIDTH must be in 1..32");
  end
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("cmos_nor_srff_bank: MODE must be in 0..3");
  end
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("cmos_nor_srff_bank: CNT_W must be in 2..16");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_nor_all;
  logic             r_conflict;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic             w_conflict;

  // S=R=1 resolution is a per-channel function of the current bit only.
  always_comb begin
    w_q_next = r_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({s[i], r[i]})
          2'b10:   w_q_next[i] = 1'b1;
          2'b01:   w_q_next[i] = 1'b0;
          2'b11: begin
            case (MODE)
              1:       w_q_next[i] = 1'b1;
              2:       w_q_next[i] = 1'b0;
              3:       w_q_next[i] = ~r_q[i];
              default: w_q_next[i] = r_q[i];
            endcase
          end
          default: w_q_next[i] = r_q[i];
        endcase
      end
    end
  end

  assign w_conflict = en & (|(s & r));

  // nor_all is taken from the next state so it matches q in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      r_nor_all  <= 1'b1;
      r_conflict <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_nor_all  <= ~(|w_q_next);
      r_conflict <= w_conflict;
    end
  end

  // A clear on the same edge as a conflict leaves the count at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_conflict && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q            = r_q;
  assign qn           = ~r_q;
  assign nor_all      = r_nor_all;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;

endmodule

// File: doc/cmos_nor_srff_bank.md
Name: cmos_nor_srff_bank

Overview:
- Parametrised, clocked successor to the switch-level NOR gate. It is a bank of WIDTH set/reset flip-flops with NOR-latch semantics: complementary q/qn outputs, and S=R=1 forbidden-input resolution selected by MODE.
- Adds status outputs: a registered all-clear indicator (NOR-reduction of the state), a registered conflict flag, and a saturating conflict counter.
- Sits between CMOS gate-level exercises and higher-level sequential blocks as the reusable storage primitive.

Parameters:
- WIDTH, 4, number of independent SR channels (1..32).
- MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
- CNT_W, 8, width of the saturating conflict counter (2..16).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  update enable; when 0, all q bits hold.
- s  input  WIDTH  per-channel set request.
- r  input  WIDTH  per-channel reset request.
- clr_cnt  input  1  synchronous clear of conflict_cnt.
- q  output  WIDTH  registered channel state.
- qn  output  WIDTH  always bitwise complement of q.
- nor_all  output  1  registered; 1 when every bit of q is 0.
- conflict  output  1  registered; 1 if any channel had s=r=1 with en=1 on the previous edge.
- conflict_cnt  output  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (rst=1 at an edge) takes precedence over all other inputs. Reset values: q=0, qn=all ones, nor_all=1, conflict=0, conflict_cnt=0. A reset issued mid-operation discards any pending request in that cycle.
- Latency: 1 cycle from s/r/en to q/qn. nor_all is derived from the next-state value and registered on the same edge, so nor_all always agrees with the q visible in the same cycle (no extra lag).
- Per-channel next state when en=1:
  - s=0, r=0: hold.
  - s=1, r=0: q=1.
  - s=0, r=1: q=0.
  - s=1, r=1 is resolved by MODE: 0 hold, 1 q=1, 2 q=0, 3 q=~q.
- Channels are fully independent; any mix of requests in one cycle is legal.
- en=0: q holds regardless of s/r, conflict registers 0, and the counter does not increment.
- qn is never driven independently: qn==~q in every cycle, including reset. q=qn is illegal and must never occur.
- conflict:
  - Set to 1 on an edge where en=1 and (s&r)!=0; otherwise 0. It is a one-cycle pulse per offending cycle.
  - Multiple conflicting channels in one cycle still count as one event.
- conflict_cnt:
  - Increments by 1 on each edge where the conflict condition holds.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt=1 forces 0 on that edge.
  - clr_cnt and a conflict on the same edge: the clear wins and the result is 0, with the conflict flag still asserted.
- No combinational path from inputs to outputs. All outputs are flops or complements of flops.
- MODE or WIDTH outside their legal range: elaboration error via a generate-time check.

Test Plan:
- Reset: WIDTH=4. Drive random s/r with rst=1 for 2 cycles. Required: q=4'b0000, qn=4'b1111, nor_all=1, conflict=0, conflict_cnt=0 after each edge.
- Set/reset/hold, MODE=0:
  - s=4'b0101, r=0 → next cycle q=4'b0101, qn=4'b1010, nor_all=0.
  - Then r=4'b0101 → q=0, nor_all=1.
  - Then en=0, s=4'b1111 → q stays 0.
- Conflict resolution: preload q=4'b0011, then s=r=4'b1111 for one cycle. Required q per MODE: 0 → 4'b0011, 1 → 4'b1111, 2 → 4'b0000, 3 → 4'b1100. In every case conflict=1 for exactly one cycle and conflict_cnt=1.
- Saturation: CNT_W=2. Hold s=r=4'b0001, en=1 for 6 cycles. Required conflict_cnt sequence 1,2,3,3,3,3.
- Clear vs conflict: conflict_cnt=2, then clr_cnt=1 with s=r=4'b1000 on the same edge. Required conflict_cnt=0 and conflict=1. The next conflict cycle gives conflict_cnt=1.
- Reset mid-operation: q=4'b1010 and conflict_cnt=5, then rst=1 together with s=4'b0101. Required q=0, qn=4'b1111, conflict_cnt=0; the set request is ignored.
